// File: rtl/gray_conv_pkg.sv
// Shared definitions for the Gray-converting round-robin arbiter:
// FSM state encoding, default sizes and the requester index type.
package gray_conv_pkg;

    localparam int N_REQ_DEFAULT = 4;
    localparam int DW_DEFAULT    = 4;
    localparam int CNT_W         = 8;

    // Result register occupancy; kept as plain constants for legacy tools.
    localparam logic STATE_EMPTY = 1'b0;
    localparam logic STATE_FULL  = 1'b1;

    typedef logic [1:0] req_idx_t;

endpackage

// File: rtl/rr_arb4.sv
// Four-way circular priority search: the first set request at or after ptr,
// scanning upward with wrap-around, wins.
module rr_arb4
    import gray_conv_pkg::*;
(
    input  logic [3:0] req,
    input  req_idx_t   ptr,
    output logic [3:0] grant,
    output req_idx_t   idx,
    output logic       any
);

    req_idx_t cand;

    always_comb begin
        // NOTE: every output gets a default before the search loop so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) grant = 4'b0001 << idx;
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter feeding a one-deep result register that holds the
// Gray-coded operand of the granted requester plus its index.
module gray_conv_arbiter
    import gray_conv_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [1:0]         out_id,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   conv_cnt
);

    logic          state;
    req_idx_t      rr_ptr;
    logic [3:0]    grant;
    req_idx_t      grant_idx;
    logic          grant_any;
    logic          accept;
    logic          transfer;
    logic [DW-1:0] sel_bin;
    logic [DW-1:0] sel_gray;

    rr_arb4 u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // A pop frees the register in the same cycle, so a new word can enter.
    assign accept    = (state == STATE_EMPTY) || out_ready;
    assign req_ready = (rst_n && accept && grant_any) ? grant : '0;
    assign transfer  = |(req_valid & req_ready);

    assign sel_bin  = req_data[DW*grant_idx +: DW];
    // g[DW-1] = b[DW-1], g[k] = b[k+1] ^ b[k]
    assign sel_gray = sel_bin ^ (sel_bin >> 1);

    assign out_valid = (state == STATE_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= STATE_EMPTY;
            out_data <= '0;
            out_id   <= '0;
            rr_ptr   <= '0;
            conv_cnt <= '0;
        end else if (transfer) begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples the pre-edge values, independent of statement order.
            state    <= STATE_FULL;
            out_data <= sel_gray;
            out_id   <= grant_idx;
            rr_ptr   <= grant_idx + 2'd1;
            conv_cnt <= conv_cnt + 8'd1;
        end else if (out_ready) begin
            state <= STATE_EMPTY;
        end
    end

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (fixed at 4 for this release).
REQ-002 SHALL have parameter DW, default 4, binary/Gray word width.

Ports (name, direction, width, meaning):
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, N_REQ, per-requester request valid.
REQ-006 SHALL have port req_data, input, N_REQ*DW, binary operands; requester i occupies [DW*i +: DW].
REQ-007 SHALL have port req_ready, output, N_REQ, one-hot accept strobe to the granted requester.
REQ-008 SHALL have port out_valid, output, 1, result register holds a valid result.
REQ-009 SHALL have port out_data, output, DW, Gray-coded result.
REQ-010 SHALL have port out_id, output, 2, index of the requester that owns out_data.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port conv_cnt, output, 8, count of accepted requests.

Function
REQ-013 SHALL perform the conversion g[DW-1]=b[DW-1] and g[k]=b[k+1]^b[k] for k<DW-1.
REQ-014 SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 SHALL define the accept condition as (state==EMPTY) or (out_ready==1), i.e. pass-through on pop.
REQ-016 SHALL, when accept is true and any req_valid is set, grant exactly one requester: the first set bit at or after rr_ptr, searching circularly upward.
REQ-017 SHALL assert req_ready combinationally only for the granted requester; a transfer occurs when req_valid[i] & req_ready[i].
REQ-018 SHALL register the converted word and the grant index, so out_valid rises one cycle after the transfer (latency 1).
REQ-019 SHALL, after a transfer with index g, set rr_ptr to (g+1) mod N_REQ; rr_ptr SHALL be unchanged when no transfer occurs.
REQ-020 SHALL transition FULL->EMPTY on out_ready with no new transfer, EMPTY->FULL on a transfer, and stay FULL on out_ready with a simultaneous transfer (throughput 1/cycle).
REQ-021 SHALL hold out_data, out_id and out_valid stable while FULL and out_ready==0; all req_ready SHALL be 0 in that condition.
REQ-022 SHALL ignore out_ready while EMPTY.
REQ-023 SHALL increment conv_cnt by 1 per transfer, wrapping 255->0.
REQ-024 SHALL neither assert req_ready nor change state when no req_valid bit is set.

Reset
REQ-025 SHALL, while rst_n==0 (asynchronous assertion), force state=EMPTY, out_valid=0, out_data=0, out_id=0, rr_ptr=0, conv_cnt=0 and req_ready=0.
REQ-026 SHALL discard any held result on reset mid-operation; no transfer SHALL occur in the cycle rst_n deasserts.

Structure
REQ-027 SHALL place the FSM state encoding (EMPTY, FULL), N_REQ and DW defaults in a shared package gray_conv_pkg.
REQ-028 SHALL implement the circular priority search in one sub-module, rr_arb4 (inputs req, ptr; outputs one-hot grant, index, any).
REQ-029 SHALL implement the Gray conversion as combinational logic inside gray_conv_arbiter; it SHALL NOT be a separate sub-module.

Verification
REQ-030 SHALL cover: after reset, req_valid=4'b0100, req_data[11:8]=4'b0101, out_ready=1 -> req_ready=4'b0100; next cycle out_valid=1, out_data=4'b0111, out_id=2, conv_cnt=1.
REQ-031 SHALL cover: all four requesters valid continuously with data 0,1,2,3 and out_ready=1 -> out_id sequence 0,1,2,3,0 on consecutive cycles and out_data 0000,0001,0011,0010.
REQ-032 SHALL cover: FULL with out_data=4'b1000 (input 1111) and out_ready=0 for 3 cycles -> out_data/out_id stable and req_ready=0 throughout; first pop then accepts the next request.
REQ-033 SHALL cover: rst_n pulsed low while FULL -> outputs 0 immediately (before the next clk edge) and rr_ptr=0 on the next grant.
REQ-034 SHALL cover: 256 transfers -> conv_cnt returns to 0; input 4'b1000 -> out_data 4'b1100.
